// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encodings and helpers
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // One-hot receiver states
  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    START     = 6'b000010,
    DATA      = 6'b000100,
    PARITY    = 6'b001000,
    STOP      = 6'b010000,
    WAIT_HIGH = 6'b100000
  } rx_state_t;

  // Ceiling log2, never below 1 so counters always have at least one bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_sync_bit.sv
// rtl/uart_sync_bit.sv - metastability flop chain for one asynchronous bit, resets high
module uart_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the asynchronous input through the chain; idle-high lines reset to 1
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with configurable width, parity and stop bits
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_rx,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_busy
);

  localparam int CNT_W = clog2(OVERSAMPLE);
  localparam int BIT_W = clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  rx_state_t             r_state;
  logic [CNT_W-1:0]      r_tick_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_sample;
  logic                  r_stop_err;
  logic                  r_first_stop_low;

  logic w_rx_s;
  logic w_frame_err_next;
  logic w_first_stop_low;
  logic w_data_xor;
  logic w_parity_err;
  logic w_break;

  uart_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_d    (i_rx),
    .o_q    (w_rx_s)
  );

  // Frame status as it would stand if the current stop sample were taken now
  always_comb begin
    w_frame_err_next = r_stop_err | ~w_rx_s;
    w_first_stop_low = (r_bit_cnt == '0) ? ~w_rx_s : r_first_stop_low;
    w_data_xor       = (^r_shift) ^ r_par_sample;
    w_parity_err     = 1'b0;
    if (PARITY_MODE == PARITY_EVEN) w_parity_err = w_data_xor;
    if (PARITY_MODE == PARITY_ODD)  w_parity_err = ~w_data_xor;
    w_break = (r_shift == '0) &&
              ((PARITY_MODE == PARITY_NONE) || !r_par_sample) &&
              w_first_stop_low;
  end

  // Receiver FSM: mid-bit sampling on i_tick, registered word, flags and valid strobe
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= IDLE;
      r_tick_cnt       <= '0;
      r_bit_cnt        <= '0;
      r_shift          <= '0;
      r_par_sample     <= 1'b0;
      r_stop_err       <= 1'b0;
      r_first_stop_low <= 1'b0;
      o_data           <= '0;
      o_valid          <= 1'b0;
      o_parity_err     <= 1'b0;
      o_frame_err      <= 1'b0;
      o_break          <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state    <= START;
            r_tick_cnt <= '0;
          end
        end
        START: begin
          if (i_tick) begin
            if (r_tick_cnt == HALF_TICK) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= w_rx_s ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (r_tick_cnt == LAST_TICK) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt <= '0;
                r_state   <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (i_tick) begin
            if (r_tick_cnt == LAST_TICK) begin
              r_tick_cnt   <= '0;
              r_par_sample <= w_rx_s;
              r_state      <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_tick) begin
            if (r_tick_cnt == LAST_TICK) begin
              r_tick_cnt <= '0;
              if (r_bit_cnt == LAST_STOP) begin
                r_bit_cnt        <= '0;
                r_stop_err       <= 1'b0;
                r_first_stop_low <= 1'b0;
                o_data           <= r_shift;
                o_valid          <= 1'b1;
                o_parity_err     <= w_parity_err;
                o_frame_err      <= w_frame_err_next;
                o_break          <= w_break;
                r_state          <= w_frame_err_next ? WAIT_HIGH : IDLE;
              end else begin
                r_bit_cnt        <= r_bit_cnt + 1'b1;
                r_stop_err       <= w_frame_err_next;
                r_first_stop_low <= w_first_stop_low;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          if (w_rx_s) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);

endmodule
